// File: rtl/mux4_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arb
// Purpose  : Round-robin arbiter that shares one 4:1 single-bit select path
//            among four level-sensitive requesters. It owns the mux select,
//            keeps a one-hot grant with a hold policy, and registers the
//            selected data bit together with a one-cycle valid strobe.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            req[3:0] - level request per source (bit k = source k)
//            i[3:0]   - data bit per source (bit k = source k)
//            gnt[3:0] - registered one-hot grant, 0 when idle
//            sel[1:0] - registered select, index of gnt, holds when idle
//            busy     - registered, 1 while a grant is held
//            out      - registered i[sel] captured on serviced cycles
//            out_vld  - registered, 1 for one cycle per serviced cycle
// Options  : ARB_HOLD_LIMIT_EN - when defined, an owner that has been
//            serviced MAX_HOLD times is forced off the grant if another
//            source is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arb #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out,
  output logic       out_vld
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;

  logic [0:0] r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic       r_busy;
  logic       r_out;
  logic       r_vld;

  logic [0:0] w_state_nxt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] w_sel_nxt;
  logic [1:0] w_ptr_nxt;
  logic       w_busy_nxt;
  logic       w_out_nxt;
  logic       w_vld_nxt;
  logic [2:0] w_pick;
  logic       w_grant_new;
  logic       w_service;
  logic       w_force;

  // Round-robin search: first asserted candidate starting at 'start'.
  // Result is {found, index}. The loop runs backwards so the candidate
  // closest to 'start' is the last to write, and therefore wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int n = 3; n >= 0; n--) begin
      idx = start + 2'(n);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ARB_HOLD_LIMIT_EN
  logic [CW-1:0] r_hold_cnt;

  // Forced release only when someone else is actually waiting; otherwise
  // the owner keeps the grant with the counter parked at saturation.
  assign w_force = (r_hold_cnt == CW'(MAX_HOLD)) && (|(req & ~r_gnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_grant_new) begin
      r_hold_cnt <= '0;
    end else if (w_service && (r_hold_cnt != CW'(MAX_HOLD))) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`else
  logic w_unused_cfg;

  assign w_force      = 1'b0;
  assign w_unused_cfg = ^{MAX_HOLD[0], CW[0]};
`endif

  // State register (plus the registered datapath it controls)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_busy  <= 1'b0;
      r_out   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
      r_out   <= w_out_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_out_nxt   = r_out;
    w_vld_nxt   = 1'b0;
    w_grant_new = 1'b0;
    w_service   = 1'b0;
    w_pick      = 3'b000;

    case (r_state)
      c_st_idle: begin
        w_pick = rr_pick(req, r_ptr);
      end
      c_st_grant: begin
        if (req[r_sel] && !w_force) begin
          w_service = 1'b1;
          w_vld_nxt = 1'b1;
          w_out_nxt = i[r_sel];
        end else begin
          // Owner leaves (voluntarily or forced): hand straight over to the
          // next waiting source, excluding the current owner, so there is
          // no idle bubble between grants.
          w_pick = rr_pick(req & ~r_gnt, r_ptr);
          if (!w_pick[2]) begin
            w_state_nxt = c_st_idle;
            w_gnt_nxt   = 4'b0000;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_pick[2]) begin
      w_grant_new = 1'b1;
      w_state_nxt = c_st_grant;
      w_gnt_nxt   = 4'b0001 << w_pick[1:0];
      w_sel_nxt   = w_pick[1:0];
      w_ptr_nxt   = w_pick[1:0] + 2'd1;
      w_busy_nxt  = 1'b1;
    end
  end

  // Output logic: every output comes straight from a register
  always_comb begin
    gnt     = r_gnt;
    sel     = r_sel;
    busy    = r_busy;
    out     = r_out;
    out_vld = r_vld;
  end

endmodule
`default_nettype wire
